id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  in_instr holds an instruction.
REQ-006 in_ready  out  1  stage accepts in_instr this cycle.
REQ-007 in_instr  in  32  RV32I instruction word.
REQ-008 wb_en  in  1  register write strobe from writeback.
REQ-009 wb_rd  in  5  writeback destination register.
REQ-010 wb_data  in  32  writeback data.
REQ-011 flush  in  1  discard the held and the incoming instruction.
REQ-012 out_valid  out  1  output bundle valid for the execute stage.
REQ-013 out_ready  in  1  execute stage consumes the bundle.
REQ-014 out_a  out  32  ALU operand a (rs1 value).
REQ-015 out_b  out  32  ALU operand b (rs2 value or sign-extended immediate).
REQ-016 out_alu_control  out  4  ALU operation code.
REQ-017 out_rd  out  5  destination register.
REQ-018 out_reg_write  out  1  result is to be written back.
REQ-019 out_illegal  out  1  instruction unsupported; no write-back.

Function
REQ-020 Register file: 32 x 32 bit, two combinational read ports (rs1 = instr[19:15], rs2 = instr[24:20]), one write port written on the clk edge when wb_en = 1 and wb_rd != 0.
REQ-021 x0 reads 0 always; writes to x0 are ignored.
REQ-022 Same-cycle bypass: if wb_en = 1, wb_rd != 0 and wb_rd equals rs1/rs2, that operand takes wb_data.
REQ-023 R-type (opcode 0110011): out_b = rs2 value; I-type ALU (opcode 0010011): out_b = sign-extended instr[31:20].
REQ-024 ALU codes: ADD 0010, SUB 0110, SLT 0111, XOR 1100, OR 0001, AND 0000.
REQ-025 funct3 decode: 000 -> ADD (SUB only for R-type with funct7 0100000), 010 -> SLT, 100 -> XOR, 110 -> OR, 111 -> AND; ADDI ignores instr[30].
REQ-026 Any other opcode, funct3 (001, 011, 101), or R-type funct7 other than 0000000/0100000 -> out_illegal = 1, out_reg_write = 0, out_alu_control = 0000, out_a/out_b = 0; instruction still occupies the slot.
REQ-027 Valid legal instructions drive out_reg_write = 1 when rd != 0, else 0.
REQ-028 Handshake: transfer when in_valid & in_ready; in_ready = !out_valid | out_ready (combinational); latency exactly 1 cycle from acceptance to out_valid.
REQ-029 While out_valid = 1 and out_ready = 0, all out_* hold stable; operands captured at acceptance are not re-read.
REQ-030 Simultaneous consume and accept: new bundle loaded, out_valid stays 1, no bubble.
REQ-031 flush = 1: next cycle out_valid = 0; an instruction presented that cycle is accepted (in_ready = 1) and discarded; flush has priority over load.
REQ-032 Register file writes are unaffected by flush and stalls.
REQ-033 RAW hazards across in-flight instructions are not detected here; upstream interlocks own them.

Reset
REQ-034 rst_n low: out_valid = 0, out_a = out_b = 0, out_alu_control = 0000, out_rd = 0, out_reg_write = 0, out_illegal = 0, all 32 registers = 0, immediately and regardless of clk.
REQ-035 Reset mid-stall drops the held bundle; first acceptance possible on the first clk edge after rst_n rises.

Structure
REQ-036 Shared package rv32i_pkg holds opcode constants, funct3/funct7 constants, and the ALU control codes of REQ-024.
REQ-037 Register file is a separate sub-module named regfile; decode, bypass and output register live in id_ex_stage.

Verification
REQ-038 Reset, then ADDI x1,x0,-5 (0xFFB00093) -> one cycle later out_valid = 1, out_a = 0, out_b = 0xFFFFFFFB, code 0010, out_rd = 1, out_reg_write = 1.
REQ-039 wb x2 = 7 and x3 = 9 earlier; SUB x4,x2,x3 (0x40310233) -> out_a = 7, out_b = 9, code 0110; SLT variant -> code 0111.
REQ-040 Bypass: wb_en = 1, wb_rd = 5, wb_data = 0x1234 in same cycle as XOR x6,x5,x0 -> out_a = 0x1234, code 1100.
REQ-041 out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs stable, no instruction lost or duplicated after release; back-to-back stream at out_ready = 1 sustains 1 per cycle.
REQ-042 SLL (funct3 001) -> out_illegal = 1, out_reg_write = 0; flush while stalled -> out_valid = 0 next cycle.
REQ-043 rst_n asserted asynchronously mid-stall -> out_valid = 0 before next edge; x1 reads 0 afterwards.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I decode constants for the ID/EX slice:
//   - major opcodes for register-register and register-immediate ALU ops
//   - funct3 / funct7 encodings of the supported ALU operations
//   - 4-bit ALU control codes consumed by the execute stage
//   - the ID/EX bundle type held in the pipeline register
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int RV_XLEN = 32;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;   // R-type ALU
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;   // I-type ALU

    // funct3 encodings of the supported operations
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 encodings accepted on R-type
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;   // selects SUB on funct3 000

    // ALU control codes
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_XOR = 4'b1100
    } alu_op_e;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic [RV_XLEN-1:0] a;
        logic [RV_XLEN-1:0] b;
        alu_op_e            alu;
        logic [4:0]         rd;
        logic               reg_write;
        logic               illegal;
    } idex_bundle_t;

endpackage

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 32 x XLEN integer register file, two combinational read ports and one
// synchronous write port. x0 is hard-wired to zero: writes to it are dropped
// and reads of it return zero. All registers clear on asynchronous reset,
// which is why this is built from flops rather than inferred block RAM.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rs1_addr, rs1_data  read port 1 (combinational)
//   rs2_addr, rs2_data  read port 2 (combinational)
//   we, wr_addr, wr_data  write port, sampled on the rising edge of clk
// ---------------------------------------------------------------------------
module regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs_reg [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && (wr_addr != 5'd0)) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    // Entry 0 is never written, but the explicit zero keeps x0 reads
    // independent of its storage.
    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs_reg[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs_reg[rs2_addr];

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// RV32I decode stage plus ID/EX pipeline register for a small integer ALU
// subset (ADD/SUB/SLT/XOR/OR/AND and their immediate forms). Reads operands
// from the register file with same-cycle writeback bypass, decodes the ALU
// control, and holds the result bundle behind a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_instr is the RV32I word
//   wb_en/wb_rd/wb_data   register file write port from writeback
//   flush                 drop the held bundle and the incoming instruction
//   out_valid/out_ready   downstream handshake to execute
//   out_a, out_b          ALU operands (rs1, rs2 or sign-extended immediate)
//   out_alu_control       ALU operation code
//   out_rd, out_reg_write destination register and its write enable
//   out_illegal           instruction outside the supported subset
// ---------------------------------------------------------------------------
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_alu_control,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_illegal
);

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    // Register file and writeback bypass
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;
    logic            wb_write;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign wb_write = wb_en && (wb_rd != 5'd0);

    regfile #(.XLEN(XLEN)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs1_data (rf_rs1_data),
        .rs2_addr (rs2),
        .rs2_data (rf_rs2_data),
        .we       (wb_write),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // The array only updates at the edge, so a write landing this cycle must
    // be forwarded or the instruction would see the stale value.
    assign rs1_val = (wb_write && (wb_rd == rs1)) ? wb_data : rf_rs1_data;
    assign rs2_val = (wb_write && (wb_rd == rs2)) ? wb_data : rf_rs2_data;

    // Decode
    logic         is_r;
    logic         is_i;
    logic         f3_ok;
    logic         f7_ok;
    logic         legal;
    idex_bundle_t dec_next;

    assign is_r  = (opcode == OPC_OP);
    assign is_i  = (opcode == OPC_OP_IMM);
    assign f3_ok = funct3 inside {F3_ADD_SUB, F3_SLT, F3_XOR, F3_OR, F3_AND};
    assign f7_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
    // funct7 only qualifies R-type; for I-type those bits are immediate.
    assign legal = f3_ok && (is_i || (is_r && f7_ok));

    always_comb begin
        dec_next         = '0;
        dec_next.alu     = ALU_AND;
        dec_next.rd      = rd;
        dec_next.illegal = !legal;
        if (legal) begin
            dec_next.a         = rs1_val;
            dec_next.b         = is_r ? rs2_val : {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            dec_next.reg_write = (rd != 5'd0);
            case (funct3)
                // ADDI carries immediate bits in funct7, so SUB is R-type only.
                F3_ADD_SUB: dec_next.alu = (is_r && (funct7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
                F3_SLT:     dec_next.alu = ALU_SLT;
                F3_XOR:     dec_next.alu = ALU_XOR;
                F3_OR:      dec_next.alu = ALU_OR;
                default:    dec_next.alu = ALU_AND;
            endcase
        end
    end

    // ID/EX pipeline register
    idex_bundle_t bundle_reg;
    logic         out_valid_reg;

    // During a flush the incoming instruction is taken and thrown away, so
    // upstream never stalls on a flush cycle.
    assign in_ready = flush || !out_valid_reg || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            bundle_reg    <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (in_ready) begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                bundle_reg <= dec_next;
            end
        end
    end

    assign out_valid       = out_valid_reg;
    assign out_a           = bundle_reg.a;
    assign out_b           = bundle_reg.b;
    assign out_alu_control = bundle_reg.alu;
    assign out_rd          = bundle_reg.rd;
    assign out_reg_write   = bundle_reg.reg_write;
    assign out_illegal     = bundle_reg.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed scenarios followed by randomized traffic against a cycle-level
// reference model (register array, expected output bundle and valid flag).
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_alu_control;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_illegal;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .wb_en           (wb_en),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_a           (out_a),
        .out_b           (out_b),
        .out_alu_control (out_alu_control),
        .out_rd          (out_rd),
        .out_reg_write   (out_reg_write),
        .out_illegal     (out_illegal)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        rw;
        logic        illegal;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_regs [32];
    logic        m_valid;
    exp_t        m_b;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_b     = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // Architectural operand value seen by an instruction this cycle.
    function automatic logic [31:0] ref_read(input logic [4:0] r, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wrd == r) return wd;
        return m_regs[r];
    endfunction

    // Mnemonic-level decode of the supported subset.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] v1, input logic [31:0] v2);
        exp_t        e;
        logic [6:0]  op = ins[6:0];
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic        known_f3 = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
                                (f3 == 3'b110) || (f3 == 3'b111);
        logic        ok;
        ok = known_f3 && ((op == OP_I) || (op == OP_R && (f7 == 7'h00 || f7 == 7'h20)));
        e = '0;
        e.rd = ins[11:7];
        if (!ok) begin
            e.illegal = 1'b1;
            return e;
        end
        e.a  = v1;
        e.b  = (op == OP_R) ? v2 : 32'($signed(ins[31:20]));
        e.rw = (ins[11:7] != 0);
        if (f3 == 3'b000)      e.alu = (op == OP_R && f7 == 7'h20) ? 4'b0110 : 4'b0010;
        else if (f3 == 3'b010) e.alu = 4'b0111;
        else if (f3 == 3'b100) e.alu = 4'b1100;
        else if (f3 == 3'b110) e.alu = 4'b0001;
        else                   e.alu = 4'b0000;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [2:0]  good_f3 [5] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
        logic [2:0]  bad_f3  [3] = '{3'b001, 3'b011, 3'b101};
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [4:0]  rs1 = 5'($urandom_range(0, 7));
        logic [4:0]  rs2 = 5'($urandom_range(0, 7));
        int          k   = $urandom_range(0, 9);
        logic [2:0]  f3g = good_f3[$urandom_range(0, 4)];
        logic [2:0]  f3b = bad_f3[$urandom_range(0, 2)];
        logic [11:0] imm = 12'($urandom);
        if (k <= 3) return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, f3g, rd, OP_R};
        if (k <= 6) return {imm, rs1, f3g, rd, OP_I};
        if (k == 7) return {7'h00, rs2, rs1, f3b, rd, ($urandom_range(0, 1) != 0) ? OP_R : OP_I};
        if (k == 8) return {7'h01, rs2, rs1, f3g, rd, OP_R};
        return $urandom;
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check_eq("out_a", out_a, m_b.a);
            check_eq("out_b", out_b, m_b.b);
            check_eq("out_alu_control", out_alu_control, m_b.alu);
            check_eq("out_rd", out_rd, m_b.rd);
            check_eq("out_reg_write", out_reg_write, m_b.rw);
            check_eq("out_illegal", out_illegal, m_b.illegal);
        end
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd, input logic ordy, input logic fl);
        logic rdy;
        exp_t nb;
        in_valid = v; in_instr = ins; wb_en = we; wb_rd = wrd; wb_data = wd;
        out_ready = ordy; flush = fl;
        #1;
        rdy = fl || !m_valid || ordy;
        check_eq("in_ready", in_ready, rdy);
        check_outputs();
        nb = ref_decode(ins, ref_read(ins[19:15], we, wrd, wd), ref_read(ins[24:20], we, wrd, wd));
        @(posedge clk);
        if (fl) begin
            m_valid = 1'b0;
            if (v) $display("flushed  instr=%h", ins);
        end else if (rdy) begin
            m_valid = v;
            if (v) begin
                m_b = nb;
                $display("accepted instr=%h a=%h b=%h alu=%b rd=%0d ill=%0b", ins, nb.a, nb.b, nb.alu, nb.rd, nb.illegal);
            end
        end
        if (we && wrd != 0) m_regs[wrd] = wd;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] i_a, i_b, i_c, i_sub, i_slt, i_xor, i_sll, i_add71;
        i_a     = {12'd100, 5'd0, 3'b000, 5'd8, OP_I};
        i_b     = {12'd200, 5'd0, 3'b000, 5'd9, OP_I};
        i_c     = {12'd300, 5'd0, 3'b110, 5'd10, OP_I};
        i_sub   = 32'h40310233;
        i_slt   = {7'h00, 5'd3, 5'd2, 3'b010, 5'd4, OP_R};
        i_xor   = {7'h00, 5'd0, 5'd5, 3'b100, 5'd6, OP_R};
        i_sll   = {7'h00, 5'd1, 5'd2, 3'b001, 5'd10, OP_R};
        i_add71 = {7'h00, 5'd0, 5'd1, 3'b000, 5'd7, OP_R};

        rst_n = 1'b0; in_valid = 0; in_instr = '0; wb_en = 0; wb_rd = '0; wb_data = '0;
        out_ready = 0; flush = 0;
        model_reset();
        #2;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_a", out_a, 0);
        check_eq("rst_out_b", out_b, 0);
        check_eq("rst_alu", out_alu_control, 0);
        check_eq("rst_rd", out_rd, 0);
        check_eq("rst_reg_write", out_reg_write, 0);
        check_eq("rst_illegal", out_illegal, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI x1,x0,-5
        step(1, 32'hFFB00093, 0, 0, 0, 1, 0);
        check_eq("addi_valid", out_valid, 1);
        check_eq("addi_a", out_a, 32'h0);
        check_eq("addi_b", out_b, 32'hFFFFFFFB);
        check_eq("addi_alu", out_alu_control, 4'b0010);
        check_eq("addi_rd", out_rd, 5'd1);
        check_eq("addi_rw", out_reg_write, 1);

        // Writeback x2 = 7, x3 = 9, then SUB and SLT
        step(0, 0, 1, 5'd2, 32'd7, 1, 0);
        step(0, 0, 1, 5'd3, 32'd9, 1, 0);
        step(1, i_sub, 0, 0, 0, 1, 0);
        check_eq("sub_a", out_a, 32'd7);
        check_eq("sub_b", out_b, 32'd9);
        check_eq("sub_alu", out_alu_control, 4'b0110);
        step(1, i_slt, 0, 0, 0, 1, 0);
        check_eq("slt_alu", out_alu_control, 4'b0111);

        // Same-cycle bypass
        step(1, i_xor, 1, 5'd5, 32'h1234, 1, 0);
        check_eq("byp_a", out_a, 32'h1234);
        check_eq("byp_alu", out_alu_control, 4'b1100);

        // Three-cycle stall with a waiting instruction, then a stream
        step(1, i_a, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, i_b, 0, 0, 0, 0, 0);
            check_eq("stall_b", out_b, 32'd100);
        end
        step(1, i_b, 0, 0, 0, 1, 0);
        check_eq("release_b", out_b, 32'd200);
        step(1, i_c, 0, 0, 0, 1, 0);
        check_eq("stream_b", out_b, 32'd300);
        step(1, i_a, 0, 0, 0, 1, 0);
        check_eq("stream_rd", out_rd, 5'd8);

        // Illegal SLL, then flush while stalled
        step(1, i_sll, 0, 0, 0, 1, 0);
        check_eq("sll_illegal", out_illegal, 1);
        check_eq("sll_rw", out_reg_write, 0);
        check_eq("sll_alu", out_alu_control, 0);
        check_eq("sll_a", out_a, 0);
        step(1, i_a, 0, 0, 0, 0, 0);
        step(1, i_b, 0, 0, 0, 0, 1);
        check_eq("flush_valid", out_valid, 0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 3) != 0, gen_instr(), $urandom_range(0, 1) != 0,
                 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset mid-stall
        step(0, 0, 1, 5'd1, 32'h55, 1, 0);
        step(1, i_a, 0, 0, 0, 1, 0);
        step(1, i_b, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_a", out_a, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, i_add71, 0, 0, 0, 1, 0);
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_x1", out_a, 32'd0);
        step(0, 0, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
